reg_scoreboard: RTL

- Issue-side hazard controller for the 32x32 register file (x0 hardwired zero).
- Tracks in-flight writes per architectural register and decides whether an instruction may issue.
- Stalls on RAW hazards and on a saturated per-register counter; releases on writeback and clears on pipeline flush.
- Sits between decode/issue and the register file write-back path.

---
 rtl/reg_scoreboard_pkg.sv | 6 +
 rtl/reg_pend_counter.sv | 37 +++
 rtl/reg_scoreboard.sv | 115 +++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Register-file geometry shared by the scoreboard and the register file.
package reg_scoreboard_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_pend_counter.sv
// Pending-write counter for one architectural register; saturating in both directions.
module reg_pend_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_max,
  output logic             is_zero
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Count state; a simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && !dec && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else if (dec && !inc && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt     = cnt_r;
  assign is_max  = (cnt_r == CNT_MAX);
  assign is_zero = (cnt_r == '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard controller: per-register pending-write tracking, RAW and
// saturation stalls, writeback release and flush.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rs1,
  input  logic                 issue_rs1_used,
  input  logic [4:0]           issue_rs2,
  input  logic                 issue_rs2_used,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_rd_we,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  input  logic                 flush,
  output logic [31:0]          busy_mask,
  output logic [CNT_W+4:0]     inflight,
  output logic                 err_underflow
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W+4:0] TOT_ONE = (CNT_W+5)'(1);

  logic [CNT_W-1:0]    cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0] is_max_s;
  logic [NUM_REGS-1:0] is_zero_s;
  logic [NUM_REGS-1:0] inc_vec_s;
  logic [NUM_REGS-1:0] dec_vec_s;

  logic rs1_busy_s, rs2_busy_s, rd_full_s, hazard_s;
  logic inc_s, dec_s, wb_nz_s, underflow_s;
  logic [CNT_W+4:0] inflight_r;
  logic err_underflow_r;

  // A source stays busy unless its last pending write retires this very cycle.
  function automatic logic src_busy(input logic idx_nz, input logic [CNT_W-1:0] c,
                                    input logic wb_hit);
    return idx_nz && (c != '0) && !(WB_BYPASS && wb_hit && (c == CNT_ONE));
  endfunction

  assign cnt_s[0]     = '0;
  assign is_max_s[0]  = 1'b0;
  assign is_zero_s[0] = 1'b1;
  assign inc_vec_s[0] = 1'b0;
  assign dec_vec_s[0] = 1'b0;

  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      assign inc_vec_s[i] = inc_s && (issue_rd == REG_IDX_W'(i));
      assign dec_vec_s[i] = dec_s && (wb_rd == REG_IDX_W'(i));
      reg_pend_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .inc     (inc_vec_s[i]),
        .dec     (dec_vec_s[i]),
        .cnt     (cnt_s[i]),
        .is_max  (is_max_s[i]),
        .is_zero (is_zero_s[i])
      );
    end
  endgenerate

  assign rs1_busy_s = issue_rs1_used &&
                      src_busy(issue_rs1 != ZERO_REG, cnt_s[issue_rs1],
                               wb_valid && (wb_rd == issue_rs1));
  assign rs2_busy_s = issue_rs2_used &&
                      src_busy(issue_rs2 != ZERO_REG, cnt_s[issue_rs2],
                               wb_valid && (wb_rd == issue_rs2));
  // A full counter may still accept an issue when a writeback frees a slot now.
  assign rd_full_s  = issue_rd_we && (issue_rd != ZERO_REG) && is_max_s[issue_rd] &&
                      !(wb_valid && (wb_rd == issue_rd));
  assign hazard_s    = rs1_busy_s || rs2_busy_s || rd_full_s;
  assign issue_ready = !hazard_s && !flush;

  assign inc_s       = issue_valid && issue_ready && issue_rd_we && (issue_rd != ZERO_REG);
  assign wb_nz_s     = wb_valid && (wb_rd != ZERO_REG);
  assign dec_s       = wb_nz_s && !is_zero_s[wb_rd];
  assign underflow_s = wb_nz_s && is_zero_s[wb_rd];

  // Total pending writes across all registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= '0;
    end else if (flush) begin
      inflight_r <= '0;
    end else if (inc_s && !dec_s) begin
      inflight_r <= inflight_r + TOT_ONE;
    end else if (dec_s && !inc_s) begin
      inflight_r <= inflight_r - TOT_ONE;
    end else begin
      inflight_r <= inflight_r;
    end
  end

  // Sticky writeback-without-pending-write error; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow_r <= 1'b0;
    end else if (!flush && underflow_s) begin
      err_underflow_r <= 1'b1;
    end else begin
      err_underflow_r <= err_underflow_r;
    end
  end

  assign busy_mask     = ~is_zero_s;
  assign inflight      = inflight_r;
  assign err_underflow = err_underflow_r;
endmodule
